// File: rtl/master_interconnect_pkg.sv
// Shared definitions for the master-side router: FSM encoding, the decode-error
// read pattern, and the slice helper for packed per-port buses.
package master_interconnect_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [31:0] DECODE_ERR_DATA_DEF = 32'hDEAD_BEEF;
endpackage

`ifndef MI_SLICE
// Port k's field of width w inside a packed per-port bus.
`define MI_SLICE(k, w) ((k) * (w)) +: (w)
`endif

// File: rtl/master_interconnect_decode.sv
// Address-MSB decoder: turns the port-select bits into a port index plus a flag
// saying whether that index names a real slave port.
module master_interconnect_decode #(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_BITS   = 1
) (
  input  logic [SEL_BITS-1:0] i_SelBits,
  output logic [SEL_BITS-1:0] o_Sel,
  output logic                o_Valid
);
  assign o_Sel   = i_SelBits;
  // One extra bit so NUM_SLAVES == 2^SEL_BITS still compares correctly.
  assign o_Valid = ({1'b0, i_SelBits} < (SEL_BITS + 1)'(NUM_SLAVES));
endmodule

// File: rtl/master_interconnect.sv
// Master-side router: decodes the address MSBs, runs Req/Lock/Gnt toward the
// selected slave arbiter, forwards one transfer at a time and returns the response.
module master_interconnect
  import master_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_BITS   = 1,
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] DECODE_ERR_DATA = DATA_WIDTH'(DECODE_ERR_DATA_DEF)
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst,
  input  logic [ADDR_WIDTH-1:0]               i_AVIn_Addr,
  input  logic [DATA_WIDTH/8-1:0]             i_AVIn_ByteEn,
  input  logic                                i_AVIn_Read,
  input  logic                                i_AVIn_Write,
  input  logic [DATA_WIDTH-1:0]               i_AVIn_WriteData,
  output logic [DATA_WIDTH-1:0]               o_AVIn_ReadData,
  output logic                                o_AVIn_WaitRequest,
  output logic [NUM_SLAVES-1:0]               o_Req,
  output logic [NUM_SLAVES-1:0]               o_Lock,
  input  logic [NUM_SLAVES-1:0]               i_Gnt,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]    o_AVOut_Addr,
  output logic [NUM_SLAVES*DATA_WIDTH/8-1:0]  o_AVOut_ByteEn,
  output logic [NUM_SLAVES-1:0]               o_AVOut_Read,
  output logic [NUM_SLAVES-1:0]               o_AVOut_Write,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]    i_AVOut_ReadData,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]    o_AVOut_WriteData,
  input  logic [NUM_SLAVES-1:0]               i_AVOut_WaitRequest
);
  state_t                r_State, w_NextState;
  logic [SEL_BITS-1:0]   r_Sel, w_NextSel;
  logic [SEL_BITS-1:0]   w_DecSel;
  logic                  w_DecValid;
  logic [NUM_SLAVES-1:0] w_SelOh;
  logic                  w_Busy, w_IsRead, w_Gnt, w_SlvWait;
  logic [DATA_WIDTH-1:0] w_SlvData;

  master_interconnect_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .SEL_BITS  (SEL_BITS)
  ) u_decode (
    .i_SelBits(i_AVIn_Addr[ADDR_WIDTH-1 -: SEL_BITS]),
    .o_Sel    (w_DecSel),
    .o_Valid  (w_DecValid)
  );

  assign o_AVOut_Addr      = {NUM_SLAVES{i_AVIn_Addr}};
  assign o_AVOut_ByteEn    = {NUM_SLAVES{i_AVIn_ByteEn}};
  assign o_AVOut_WriteData = {NUM_SLAVES{i_AVIn_WriteData}};

  assign w_SelOh   = NUM_SLAVES'(1) << r_Sel;
  assign w_Busy    = i_AVIn_Read | i_AVIn_Write;
  assign w_IsRead  = i_AVIn_Read & ~i_AVIn_Write;  // write wins when both are set
  assign w_Gnt     = |(i_Gnt & w_SelOh);
  assign w_SlvWait = |(i_AVOut_WaitRequest & w_SelOh);

  always_comb begin
    w_SlvData = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (w_SelOh[k]) w_SlvData = i_AVOut_ReadData[`MI_SLICE(k, DATA_WIDTH)];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= IDLE;
      r_Sel   <= '0;
    end else begin
      r_State <= w_NextState;
      r_Sel   <= w_NextSel;
    end
  end

  // Req/Lock/strobes come straight from state, so reset clears them at once.
  always_comb begin
    w_NextState        = r_State;
    w_NextSel          = r_Sel;
    o_Req              = '0;
    o_Lock             = '0;
    o_AVOut_Read       = '0;
    o_AVOut_Write      = '0;
    o_AVIn_WaitRequest = 1'b1;
    o_AVIn_ReadData    = '0;
    case (r_State)
      IDLE: begin
        if (w_Busy) begin
          w_NextSel   = w_DecSel;
          w_NextState = w_DecValid ? REQ : ERR;
        end
      end
      REQ: begin
        o_Req = w_SelOh;
        if (!w_Busy)    w_NextState = IDLE;
        else if (w_Gnt) w_NextState = XFER;
      end
      XFER: begin
        o_Req = w_SelOh;
        if (!w_Busy) begin
          w_NextState = IDLE;
        end else if (!w_Gnt) begin
          // Arbiter took the port back: withdraw strobes now and re-arbitrate.
          w_NextState = REQ;
        end else begin
          o_Lock             = w_SelOh;
          o_AVOut_Write      = i_AVIn_Write ? w_SelOh : '0;
          o_AVOut_Read       = w_IsRead ? w_SelOh : '0;
          o_AVIn_WaitRequest = w_SlvWait;
          o_AVIn_ReadData    = w_SlvData;
          if (!w_SlvWait) w_NextState = IDLE;
        end
      end
      ERR: begin
        o_AVIn_WaitRequest = 1'b0;
        if (w_IsRead) o_AVIn_ReadData = DECODE_ERR_DATA;
        w_NextState = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_master_interconnect.sv
// Bench for master_interconnect: directed scenarios plus randomized transfers
// checked against a memory-level model of the two slaves.
module tb_master_interconnect;
  localparam int AW = 30;
  localparam int DW = 32;

  // clock / reset
  logic i_Clk = 1'b0;
  logic i_Rst;
  always #5 i_Clk = ~i_Clk;

  // main instance: 2 ports, 1 select bit
  logic [AW-1:0]   i_AVIn_Addr;
  logic [3:0]      i_AVIn_ByteEn;
  logic            i_AVIn_Read, i_AVIn_Write;
  logic [DW-1:0]   i_AVIn_WriteData;
  logic [DW-1:0]   o_AVIn_ReadData;
  logic            o_AVIn_WaitRequest;
  logic [1:0]      o_Req, o_Lock, i_Gnt;
  logic [2*AW-1:0] o_AVOut_Addr;
  logic [7:0]      o_AVOut_ByteEn;
  logic [1:0]      o_AVOut_Read, o_AVOut_Write;
  logic [2*DW-1:0] i_AVOut_ReadData;
  logic [2*DW-1:0] o_AVOut_WriteData;
  logic [1:0]      i_AVOut_WaitRequest;

  master_interconnect #(.NUM_SLAVES(2), .SEL_BITS(1), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_AVIn_Addr(i_AVIn_Addr), .i_AVIn_ByteEn(i_AVIn_ByteEn),
    .i_AVIn_Read(i_AVIn_Read), .i_AVIn_Write(i_AVIn_Write),
    .i_AVIn_WriteData(i_AVIn_WriteData), .o_AVIn_ReadData(o_AVIn_ReadData),
    .o_AVIn_WaitRequest(o_AVIn_WaitRequest),
    .o_Req(o_Req), .o_Lock(o_Lock), .i_Gnt(i_Gnt),
    .o_AVOut_Addr(o_AVOut_Addr), .o_AVOut_ByteEn(o_AVOut_ByteEn),
    .o_AVOut_Read(o_AVOut_Read), .o_AVOut_Write(o_AVOut_Write),
    .i_AVOut_ReadData(i_AVOut_ReadData), .o_AVOut_WriteData(o_AVOut_WriteData),
    .i_AVOut_WaitRequest(i_AVOut_WaitRequest)
  );

  // second instance: 3 ports, 2 select bits, always-granting zero-wait slaves
  logic [AW-1:0]   m3_addr;
  logic            m3_rd, m3_wr;
  logic [DW-1:0]   m3_rdata;
  logic            m3_wait;
  logic [2:0]      m3_req, m3_lock, m3_ord, m3_owr;
  logic [3*AW-1:0] m3_oaddr;
  logic [11:0]     m3_obe;
  logic [3*DW-1:0] m3_owd;

  master_interconnect #(.NUM_SLAVES(3), .SEL_BITS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_dut3 (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_AVIn_Addr(m3_addr), .i_AVIn_ByteEn(4'hF),
    .i_AVIn_Read(m3_rd), .i_AVIn_Write(m3_wr),
    .i_AVIn_WriteData(32'h0), .o_AVIn_ReadData(m3_rdata),
    .o_AVIn_WaitRequest(m3_wait),
    .o_Req(m3_req), .o_Lock(m3_lock), .i_Gnt(3'b111),
    .o_AVOut_Addr(m3_oaddr), .o_AVOut_ByteEn(m3_obe),
    .o_AVOut_Read(m3_ord), .o_AVOut_Write(m3_owr),
    .i_AVOut_ReadData({3{32'h1234_5678}}), .o_AVOut_WriteData(m3_owd),
    .i_AVOut_WaitRequest(3'b000)
  );

  // slave memories (written by DUT strobes) and the expected memory model
  logic [DW-1:0] mem     [2][16] = '{default: '0};
  logic [DW-1:0] exp_mem [2][16] = '{default: '0};
  logic [DW-1:0] exp_q[$];
  int total = 0, bad = 0;
  int acc_cnt = 0;
  logic cur_sel = 1'b0;
  logic cur_wr  = 1'b0;

  always_comb begin
    i_AVOut_ReadData = '0;
    for (int k = 0; k < 2; k++)
      i_AVOut_ReadData[k*DW +: DW] = mem[k][o_AVOut_Addr[k*AW +: 4]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // per-cycle rules: routing confined to the selected port, broadcast buses, slave writes
  task automatic mon();
    logic [1:0] sel_mask;
    sel_mask = 2'b01 << cur_sel;
    chk("req_port",   64'(o_Req & ~sel_mask), 0);
    chk("lock_port",  64'(o_Lock & ~sel_mask), 0);
    chk("strobe_gnt", 64'((o_AVOut_Read | o_AVOut_Write) & ~(sel_mask & i_Gnt)), 0);
    chk("rd_supp",    64'(o_AVOut_Read & {2{cur_wr}}), 0);
    chk("bcast_addr", 64'(o_AVOut_Addr), 64'({2{i_AVIn_Addr}}));
    chk("bcast_wd",   o_AVOut_WriteData, {2{i_AVIn_WriteData}});
    for (int k = 0; k < 2; k++) begin
      if (o_AVOut_Write[k] && !i_AVOut_WaitRequest[k]) begin
        for (int b = 0; b < 4; b++)
          if (o_AVOut_ByteEn[k*4+b])
            mem[k][o_AVOut_Addr[k*AW +: 4]][b*8 +: 8] = o_AVOut_WriteData[k*DW + b*8 +: 8];
        acc_cnt++;
      end
    end
  endtask

  // driver tasks
  task automatic cyc(input logic [1:0] g, input logic [1:0] w, input bit drop);
    @(posedge i_Clk); #1;
    i_Gnt = g;
    i_AVOut_WaitRequest = w;
    if (drop) begin i_AVIn_Read = 1'b0; i_AVIn_Write = 1'b0; end
    @(negedge i_Clk);
    mon();
  endtask

  task automatic start(input logic [AW-1:0] a, input bit rd, input bit wr,
                       input logic [DW-1:0] d, input logic [3:0] be);
    @(posedge i_Clk); #1;
    i_AVIn_Addr = a; i_AVIn_Read = rd; i_AVIn_Write = wr;
    i_AVIn_WriteData = d; i_AVIn_ByteEn = be;
    cur_sel = a[AW-1]; cur_wr = wr;
    @(negedge i_Clk);
    mon();
  endtask

  task automatic expect_bus(input string tag, input logic [1:0] req, input logic [1:0] lock,
                            input logic [1:0] rd, input logic [1:0] wr, input logic wreq);
    chk({tag, "_req"},  64'(o_Req), 64'(req));
    chk({tag, "_lock"}, 64'(o_Lock), 64'(lock));
    chk({tag, "_rd"},   64'(o_AVOut_Read), 64'(rd));
    chk({tag, "_wr"},   64'(o_AVOut_Write), 64'(wr));
    chk({tag, "_wait"}, 64'(o_AVIn_WaitRequest), 64'(wreq));
  endtask

  function automatic void model_write(input logic p, input logic [3:0] idx,
                                      input logic [DW-1:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++)
      if (be[b]) exp_mem[p][idx][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // one transfer under a random arbiter (grants may come and go) and random slave waits
  task automatic xact(input logic [AW-1:0] a, input bit rd, input bit wr,
                      input logic [DW-1:0] d, input logic [3:0] be);
    int n, acc0;
    bit done;
    logic [1:0] g;
    acc0 = acc_cnt;
    if (rd && !wr) exp_q.push_back(exp_mem[a[AW-1]][a[3:0]]);
    start(a, rd, wr, d, be);
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      g = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) g[a[AW-1]] = 1'b1;
      cyc(g, 2'($urandom_range(0, 3)), 1'b0);
      n++;
      if (o_AVIn_WaitRequest === 1'b0) done = 1'b1;
    end
    chk("xact_done", 64'(done), 1);
    if (done) chk("min_latency", 64'(n >= 2), 1);
    if (rd && !wr) begin
      if (done) chk("rdata", 64'(o_AVIn_ReadData), 64'(exp_q.pop_front()));
      else exp_q.delete();
    end
    cyc(2'b00, 2'b11, 1'b1);
    chk("single_cmpl", 64'(o_AVIn_WaitRequest), 1);
    chk("slave_writes", 64'(acc_cnt - acc0), (wr && done) ? 64'd1 : 64'd0);
    if (wr) model_write(a[AW-1], a[3:0], d, be);
  endtask

  initial begin
    i_Rst = 1'b1;
    i_AVIn_Addr = '0; i_AVIn_ByteEn = 4'hF; i_AVIn_Read = 1'b0; i_AVIn_Write = 1'b0;
    i_AVIn_WriteData = '0; i_Gnt = 2'b00; i_AVOut_WaitRequest = 2'b11;
    m3_addr = '0; m3_rd = 1'b0; m3_wr = 1'b0;
    @(negedge i_Clk); @(negedge i_Clk);
    expect_bus("rst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    chk("rst_rdata", 64'(o_AVIn_ReadData), 0);
    chk("rst3_wait", 64'(m3_wait), 1);
    chk("rst3_req",  64'(m3_req | m3_lock | m3_ord | m3_owr), 0);
    i_Rst = 1'b0;

    // unmapped select on the 3-port instance: one-cycle error response
    @(posedge i_Clk); #1; m3_addr = 30'h3000_0000; m3_rd = 1'b1;
    @(negedge i_Clk); chk("err_c0_wait", 64'(m3_wait), 1);
    @(negedge i_Clk);
    chk("err_rd_wait",  64'(m3_wait), 0);
    chk("err_rd_data",  64'(m3_rdata), 64'h0000_0000_DEAD_BEEF);
    chk("err_rd_strb",  64'(m3_req | m3_lock | m3_ord | m3_owr), 0);
    @(posedge i_Clk); #1; m3_rd = 1'b0;
    @(negedge i_Clk);
    chk("err_after_wait", 64'(m3_wait), 1);
    chk("err_after_data", 64'(m3_rdata), 0);
    @(posedge i_Clk); #1; m3_addr = 30'h3FFF_FFFF; m3_wr = 1'b1;
    @(negedge i_Clk); @(negedge i_Clk);
    chk("err_wr_wait", 64'(m3_wait), 0);
    chk("err_wr_strb", 64'(m3_req | m3_lock | m3_ord | m3_owr), 0);
    chk("err_wr_data", 64'(m3_rdata), 0);
    @(posedge i_Clk); #1; m3_wr = 1'b0;

    // write to port 0, grant with the request, one slave wait cycle
    start(30'h0000_0010, 1'b0, 1'b1, 32'h1, 4'hF);
    expect_bus("t1c0", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b11, 1'b0); expect_bus("t1c1", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b11, 1'b0); expect_bus("t1c2", 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
    chk("t1_wdata", 64'(o_AVOut_WriteData[31:0]), 1);
    cyc(2'b01, 2'b10, 1'b0); expect_bus("t1c3", 2'b01, 2'b01, 2'b00, 2'b01, 1'b0);
    cyc(2'b00, 2'b11, 1'b1); expect_bus("t1c4", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    model_write(1'b0, 4'h0, 32'h1, 4'hF);

    // read from port 1
    xact(30'h2000_0004, 1'b0, 1'b1, 32'hCAFE_0001, 4'hF);
    start(30'h2000_0004, 1'b1, 1'b0, 32'h0, 4'hF);
    expect_bus("t2c0", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b10, 2'b00, 1'b0); expect_bus("t2c1", 2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b10, 2'b00, 1'b0); expect_bus("t2c2", 2'b10, 2'b10, 2'b10, 2'b00, 1'b0);
    chk("t2_rdata", 64'(o_AVIn_ReadData), 64'h0000_0000_CAFE_0001);
    cyc(2'b00, 2'b11, 1'b1); expect_bus("t2c3", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    // grant withheld five cycles
    start(30'h0000_0003, 1'b0, 1'b1, 32'h0BAD_F00D, 4'hF);
    for (int i = 0; i < 5; i++) begin
      cyc(2'b00, 2'b00, 1'b0); expect_bus("t4wait", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    end
    cyc(2'b01, 2'b00, 1'b0); expect_bus("t4gnt", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 1'b0); expect_bus("t4xfer", 2'b01, 2'b01, 2'b00, 2'b01, 1'b0);
    cyc(2'b00, 2'b11, 1'b1); expect_bus("t4idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    model_write(1'b0, 4'h3, 32'h0BAD_F00D, 4'hF);

    // grant lost mid-transfer, then regained
    start(30'h0000_0005, 1'b0, 1'b1, 32'hA5A5_5A5A, 4'hF);
    cyc(2'b01, 2'b11, 1'b0); expect_bus("t5req",  2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b11, 1'b0); expect_bus("t5xfer", 2'b01, 2'b01, 2'b00, 2'b01, 1'b1);
    cyc(2'b00, 2'b11, 1'b0); expect_bus("t5lost", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b00, 2'b11, 1'b0); expect_bus("t5retry", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b11, 1'b0); expect_bus("t5regnt", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 1'b0); expect_bus("t5done", 2'b01, 2'b01, 2'b00, 2'b01, 1'b0);
    chk("t5_wdata", 64'(o_AVOut_WriteData[31:0]), 64'h0000_0000_A5A5_5A5A);
    cyc(2'b00, 2'b11, 1'b1);
    model_write(1'b0, 4'h5, 32'hA5A5_5A5A, 4'hF);

    // master abandons the request while stalled
    start(30'h0000_0007, 1'b0, 1'b1, 32'h77, 4'hF);
    cyc(2'b01, 2'b11, 1'b0); expect_bus("tdrop_req", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b11, 1'b1); expect_bus("tdrop_cyc", 2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    cyc(2'b01, 2'b00, 1'b0); expect_bus("tdrop_idle", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    // reset during a transfer, then a normal write to port 1
    start(30'h2000_0009, 1'b0, 1'b1, 32'h6666, 4'hF);
    cyc(2'b10, 2'b11, 1'b0);
    cyc(2'b10, 2'b11, 1'b0); expect_bus("t6xfer", 2'b10, 2'b10, 2'b00, 2'b10, 1'b1);
    #2; i_Rst = 1'b1; #1;
    expect_bus("t6rst", 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    i_AVIn_Write = 1'b0;
    @(negedge i_Clk); i_Rst = 1'b0;
    xact(30'h2000_0009, 1'b0, 1'b1, 32'h1357_9BDF, 4'hF);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      int op;
      logic [AW-1:0] a;
      op = $urandom_range(0, 2);
      a = '0;
      a[AW-1] = 1'($urandom_range(0, 1));
      a[3:0]  = 4'($urandom_range(0, 15));
      xact(a, op != 1, op != 0, $urandom, 4'($urandom_range(1, 15)));
    end

    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 16; i++)
        chk("mem_final", 64'(mem[p][i]), 64'(exp_mem[p][i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
